// File: rtl/divisor_seq_pkg.sv
// alu_pkg: shared divider state encoding and magnitude helper.
package alu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  localparam int MAXW = 64;
  function automatic logic [MAXW-1:0] abs_val(input logic [MAXW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/divisor_seq_div_step.sv
// div_step: one restoring division iteration (shift in dividend bit, trial-subtract divisor).
module div_step #(parameter int n = 24) (
  input  logic [n:0]   pr,
  input  logic         msb,
  input  logic [n-1:0] mb,
  output logic [n:0]   pr_nx,
  output logic         qb
);
  logic [n+1:0] sh;
  assign sh = {pr, msb};
  assign qb = sh >= (n+2)'(mb);
  assign pr_nx = qb ? (n+1)'(sh - (n+2)'(mb)) : sh[n:0];
endmodule

// File: rtl/divisor_seq.sv
// divisor_seq: iterative radix-2 restoring signed divider with start/done handshake.
// Define DIV_UNSIGNED_MODE_EN to add the sgn input selecting signed/unsigned operands.
module divisor_seq import alu_pkg::*; #(parameter int n = 24) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef DIV_UNSIGNED_MODE_EN
  input  logic         sgn,
`endif
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] out,
  output logic [n-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         dbz,
  output logic         car
);
  localparam int CW = $clog2(n);
  div_state_t state, nstate;
  logic s_in, sg, neg_q, neg_r, qb, dbz_c, ovf_c;
  logic [n:0] pr, pr_nx;
  logic [n-1:0] dq, mb, a_r, b_r;
  logic [CW-1:0] cnt;
`ifdef DIV_UNSIGNED_MODE_EN
  assign s_in = sgn;
`else
  assign s_in = 1'b1;
`endif
  div_step #(.n(n)) u_step (.pr(pr), .msb(dq[n-1]), .mb(mb), .pr_nx(pr_nx), .qb(qb));
  assign dbz_c = b_r == '0;
  assign ovf_c = sg && a_r == {1'b1, {(n-1){1'b0}}} && b_r == '1;
  assign busy = state == CALC || state == FIX;
  assign done = state == DONE;
  assign car = 1'b0;
  always_comb begin
    nstate = state == IDLE ? (start ? (B == '0 ? FIX : CALC) : IDLE) :
             state == CALC ? (cnt == '0 ? FIX : CALC) :
             state == FIX  ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pr, dq, mb, a_r, b_r, cnt, sg, neg_q, neg_r} <= '0;
      {out, rem, overflow, dbz} <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= A;
          b_r <= B;
          sg <= s_in;
          mb <= n'(abs_val(MAXW'(B), s_in & B[n-1]));
          dq <= n'(abs_val(MAXW'(A), s_in & A[n-1]));
          pr <= '0;
          cnt <= CW'(n-1);
          neg_q <= s_in & (A[n-1] ^ B[n-1]);
          neg_r <= s_in & A[n-1];
        end
        CALC: begin
          pr <= pr_nx;
          dq <= {dq[n-2:0], qb};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          out <= dbz_c ? '1 : neg_q ? -dq : dq;
          rem <= dbz_c ? a_r : neg_r ? -pr[n-1:0] : pr[n-1:0];
          dbz <= dbz_c;
          overflow <= ovf_c;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divisor_seq.sv
// tb_divisor_seq: directed vectors with a scoreboard queue checked on every done pulse.
module tb_divisor_seq;
  localparam int N = 24;
  typedef struct packed {logic [N-1:0] q, r; logic ov, dz;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, sgn = 1;
  logic [N-1:0] a = '0, b = '0, out, rem;
  logic busy, done, overflow, dbz, car;
  int cyc = 0, tests = 0, fails = 0, k = 0;
  exp_t sb[$];

  divisor_seq #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef DIV_UNSIGNED_MODE_EN
    .sgn(sgn),
`endif
    .A(a), .B(b), .out(out), .rem(rem), .busy(busy), .done(done),
    .overflow(overflow), .dbz(dbz), .car(car)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("out", out, e.q);
        chk("rem", rem, e.r);
        chk("overflow", N'(overflow), N'(e.ov));
        chk("dbz", N'(dbz), N'(e.dz));
        chk("car", N'(car), '0);
      end
    end
  end

  task automatic kick(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sgn = s; start = 1;
    k = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int lat);
    int i;
    i = 0;
    chk("busy_after_start", N'(busy), N'(1));
    while (!done && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("done_latency", N'(cyc - k), N'(lat));
    chk("busy_in_done", N'(busy), '0);
  endtask

  task automatic op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                    input logic [N-1:0] q, input logic [N-1:0] r, input logic ov, input logic dz);
    sb.push_back('{q, r, ov, dz});
    kick(x, y, s);
    wait_done(dz ? 2 : N + 2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", out, '0);
    chk("reset_rem", rem, '0);
    chk("reset_flags", N'({busy, done, overflow, dbz}), '0);
    rst_n = 1;
    op(24'd100, 24'd7, 1, 24'd14, 24'd2, 0, 0);
    op(-24'sd100, 24'd7, 1, 24'hFFFFF2, 24'hFFFFFE, 0, 0);
    op(24'd100, -24'sd7, 1, 24'hFFFFF2, 24'd2, 0, 0);
    op(-24'sd100, -24'sd7, 1, 24'd14, 24'hFFFFFE, 0, 0);
    op(24'd5, 24'd0, 1, 24'hFFFFFF, 24'd5, 0, 1);
    op(24'h800000, 24'hFFFFFF, 1, 24'h800000, 24'd0, 1, 0);
    op(24'd0, 24'd5, 1, 24'd0, 24'd0, 0, 0);
    op(24'h7FFFFF, 24'd1, 1, 24'h7FFFFF, 24'd0, 0, 0);
    op(24'h800000, 24'd2, 1, 24'hC00000, 24'd0, 0, 0);
    op(24'd7, 24'd100, 1, 24'd0, 24'd7, 0, 0);
    op(-24'sd7, 24'd100, 1, 24'd0, 24'hFFFFF9, 0, 0);
    op(24'h800000, 24'd0, 1, 24'hFFFFFF, 24'h800000, 0, 1);
    // second start while busy must be dropped
    sb.push_back('{24'd16, 24'd2, 1'b0, 1'b0});
    kick(24'd50, 24'd3, 1);
    repeat (4) @(negedge clk);
    a = 24'd1000; b = 24'd10; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(N + 2);
    repeat (5) @(negedge clk);
    // reset in the middle of a division aborts it
    kick(24'd1234, 24'd5, 1);
    repeat (9) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_out", out, '0);
    chk("abort_rem", rem, '0);
    chk("abort_flags", N'({busy, done, overflow, dbz}), '0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (30) @(negedge clk);
    op(24'd1000, 24'd10, 1, 24'd100, 24'd0, 0, 0);
`ifdef DIV_UNSIGNED_MODE_EN
    op(24'hFFFFFF, 24'd2, 0, 24'h7FFFFF, 24'd1, 0, 0);
    op(24'h800000, 24'hFFFFFF, 0, 24'd0, 24'h800000, 0, 0);
    op(24'd9, 24'd0, 0, 24'hFFFFFF, 24'd9, 0, 1);
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", N'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Multi-cycle, parametrised signed/unsigned integer divider for the ALU.
- Iterative radix-2 restoring algorithm, one quotient bit per clock.
- Produces quotient and remainder.
- Flags: divide-by-zero and overflow; carry output kept for ALU flag-bus uniformity.
- Start/done handshake lets the control unit stall while the division completes.

Parameters:
- n, 24: operand, quotient and remainder width in bits (n >= 4).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- A  input  n  dividend (signed two's complement unless unsigned mode is selected).
- B  input  n  divisor.
- out  output  n  quotient.
- rem  output  n  remainder.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; out, rem and the flags are valid from this cycle.
- overflow  output  1  quotient not representable (A = -2^(n-1), B = -1, signed).
- dbz  output  1  divide by zero.
- car  output  1  constant 0.

Behaviour:
- Reset (asynchronous, rst_n = 0): state IDLE; out = 0, rem = 0, busy = 0, done = 0, overflow = 0, dbz = 0; internal counter and registers cleared. Reset mid-operation aborts the division; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start = 1 latches A and B, computes |A| and |B| and the result signs, clears the partial remainder, sets count = n-1 and busy = 1.
  - B = 0: go to FIX directly and skip CALC.
  - Otherwise: go to CALC.
- CALC, one iteration per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract |B|; if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - count = 0: go to FIX; else count decrements.
- FIX:
  - Quotient negated if sign(A) xor sign(B).
  - Remainder takes the sign of A; truncation toward zero, so A = out*B + rem.
  - Results and flags registered into the outputs. Go to DONE.
- DONE: done = 1 and busy = 0 for one cycle; go to IDLE.
- Outputs hold their values until the next FIX.
- Latency:
  - Start sampled in cycle k: done is high in cycle k+n+2.
  - B = 0: done is high in cycle k+2.
- start while busy or in DONE is ignored (no queueing).
- start in the same cycle the DONE state is left (back to IDLE) is accepted normally.
- Divide by zero: out = all ones, rem = A, dbz = 1, overflow = 0.
- Signed overflow (A = -2^(n-1), B = -1): out = -2^(n-1) (wrapped), rem = 0, overflow = 1.
- All other cases: overflow = 0, dbz = 0.
- Internal partial remainder is n+1 bits wide, so the trial subtraction never loses the sign.
- A = -2^(n-1) magnitude is handled as an unsigned n-bit value 2^(n-1).

Optional Feature:
- Macro: DIV_UNSIGNED_MODE_EN.
- Defined:
  - Extra input port sgn (1 bit), latched with start.
  - sgn = 1 selects signed behaviour as above.
  - sgn = 0 treats A and B as unsigned: no sign fix-up, overflow is always 0, divide-by-zero rule unchanged.
- Undefined: no sgn port; always signed.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, FIX, DONE}.
  - Helper function abs_val for n-bit magnitude.
- Sub-module div_step (combinational, one restoring iteration).
  - Inputs: partial remainder (n+1 bits), dividend MSB, |B|.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once, used every CALC cycle.

Test Plan:
- n = 24, A = 100, B = 7, start pulse: done in cycle k+26; out = 14, rem = 2, flags 0; busy high cycles k+1..k+25.
- A = -100, B = 7: out = -14 (0xFFFFF2), rem = -2 (0xFFFFFE); A = 100, B = -7: out = -14, rem = 2.
- A = 5, B = 0: done in cycle k+2; out = 0xFFFFFF, rem = 5, dbz = 1, overflow = 0.
- A = 0x800000, B = 0xFFFFFF (-1): out = 0x800000, rem = 0, overflow = 1, dbz = 0.
- Start at cycle k with A = 50, B = 3, re-assert start at k+5 with other operands: ignored; out = 16, rem = 2 at k+26.
- Start, then rst_n = 0 at k+10: all outputs 0 immediately, no done pulse; a new start after release completes normally.
- With DIV_UNSIGNED_MODE_EN and sgn = 0, A = 0xFFFFFF, B = 2: out = 0x7FFFFF, rem = 1, overflow = 0.
